// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg
//   Shared definitions for the configuration-chain loader: FSM state
//   encoding and the counter-width helper used for both the bit counter
//   and the prog_clk half-period timer.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } cfg_state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cfg_clk_div.sv
// cfg_clk_div
//   Half-period timer for prog_clk. Down-counter reloaded with CLK_DIV-1;
//   tc pulses on the last cycle of every CLK_DIV-cycle window while en is
//   high, and the counter reloads itself on that same edge so consecutive
//   windows run back to back.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous reload to CLK_DIV-1
//   en     in   count enable
//   tc     out  terminal count (combinational, qualified by en)
module cfg_clk_div
  import cfg_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = cnt_width(CLK_DIV);
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - W'(1);
    end
  end

  assign tc = en && (cnt == '0);

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader
//   Streams a bitstream (bytes, LSB first) into a serial BEL programming
//   chain of CHAIN_LEN bits, generating prog_clk at 2*CLK_DIV clk cycles per
//   bit. The bit leaving the chain tail is XOR-accumulated into old_parity.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   start       in   load request, honoured only in IDLE
//   byte_in     in   bitstream byte
//   byte_valid  in   byte_in valid
//   byte_ready  out  byte accepted this cycle when byte_valid is high
//   prog_clk    out  chain shift clock
//   prog_en     out  chain shift enable
//   prog_in     out  serial bit into the chain head
//   prog_out    in   serial bit from the chain tail
//   busy        out  load in progress
//   done        out  one-cycle completion pulse
//   old_parity  out  XOR of every prog_out bit sampled during the last load
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for start
// ST_FETCH     | waiting for a byte; prog_clk low, prog_en high
// ST_SHIFT_LO  | prog_in driven with current bit, prog_clk low for CLK_DIV
// ST_SHIFT_HI  | prog_clk high for CLK_DIV, prog_out sampled on entry
// ST_DONE      | done pulse, chain disabled, old_parity published
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_in,
  input  logic       prog_out,
  output logic       busy,
  output logic       done,
  output logic       old_parity
);

  localparam int unsigned CNT_W = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  cfg_state_e       state;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] bit_cnt;
  logic             parity;
  logic             tc;
  logic             timer_en;
  logic             timer_clr;
  logic             last_bit;
  logic             byte_end;

  assign timer_en  = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
  assign timer_clr = !timer_en;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign byte_end  = (state == ST_SHIFT_HI) && tc && (bit_idx == 3'd7) && !last_bit;

  // Ready is also raised in the final cycle of a byte's last high phase so
  // a waiting byte is taken without inserting a FETCH cycle; this keeps
  // every bit at exactly 2*CLK_DIV cycles when the source never stalls.
  assign byte_ready = (state == ST_FETCH) || byte_end;

  cfg_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst_n(rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      prog_clk   <= 1'b0;
      prog_en    <= 1'b0;
      prog_in    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      old_parity <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bit_cnt <= '0;
            parity  <= 1'b0;
            prog_en <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (byte_valid && byte_ready) begin
            shreg   <= byte_in;
            bit_idx <= 3'd0;
            prog_in <= byte_in[0];
            state   <= ST_SHIFT_LO;
          end
        end

        ST_SHIFT_LO: begin
          if (tc) begin
            // prog_out is still the pre-shift tail value on this edge.
            prog_clk <= 1'b1;
            parity   <= parity ^ prog_out;
            state    <= ST_SHIFT_HI;
          end
        end

        ST_SHIFT_HI: begin
          if (tc) begin
            prog_clk <= 1'b0;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
              prog_en    <= 1'b0;
              done       <= 1'b1;
              old_parity <= parity;
              state      <= ST_DONE;
            end else if (bit_idx == 3'd7) begin
              if (byte_valid) begin
                shreg   <= byte_in;
                bit_idx <= 3'd0;
                prog_in <= byte_in[0];
                state   <= ST_SHIFT_LO;
              end else begin
                state <= ST_FETCH;
              end
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              prog_in <= shreg[1];
              state   <= ST_SHIFT_LO;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader
//   Three loader instances: (CHAIN_LEN=12, CLK_DIV=2), (64, 2) and (8, 1),
//   each driving a behavioural shift-register chain. Stimulus pushes the
//   expected bit stream and completion record into queues; an independent
//   monitor pops them on every prog_clk rising edge and done pulse.
module tb_cfg_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  logic [2:0] start;
  logic [2:0] byte_valid;
  logic [7:0] byte_in [3];
  wire  [2:0] byte_ready, prog_clk, prog_en, prog_in, prog_out, busy, done, old_parity;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cfg_loader #(
      .CHAIN_LEN(g == 0 ? 12 : (g == 1 ? 64 : 8)),
      .CLK_DIV  (g == 2 ? 1 : 2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .byte_in   (byte_in[g]),
      .byte_valid(byte_valid[g]),
      .byte_ready(byte_ready[g]),
      .prog_clk  (prog_clk[g]),
      .prog_en   (prog_en[g]),
      .prog_in   (prog_in[g]),
      .prog_out  (prog_out[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .old_parity(old_parity[g])
    );
  end

  function automatic int clen(input int i);
    return (i == 0) ? 12 : ((i == 1) ? 64 : 8);
  endfunction

  function automatic int cdiv(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  // Downstream prog chains (not reset: configuration survives a loader reset)
  logic [11:0] hch0 = '0;
  logic [63:0] hch1 = '0;
  logic [7:0]  hch2 = '0;
  int          hw_edges [3] = '{0, 0, 0};

  always @(posedge prog_clk[0]) begin
    if (prog_en[0]) hch0 <= {hch0[10:0], prog_in[0]};
    hw_edges[0] <= hw_edges[0] + 1;
  end
  always @(posedge prog_clk[1]) begin
    if (prog_en[1]) hch1 <= {hch1[62:0], prog_in[1]};
    hw_edges[1] <= hw_edges[1] + 1;
  end
  always @(posedge prog_clk[2]) begin
    if (prog_en[2]) hch2 <= {hch2[6:0], prog_in[2]};
    hw_edges[2] <= hw_edges[2] + 1;
  end
  assign prog_out[0] = hch0[11];
  assign prog_out[1] = hch1[63];
  assign prog_out[2] = hch2[7];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    int inst;
    bit parity;
    int edges;
  } done_rec_t;

  bit        exp_bits [$];
  done_rec_t exp_done [$];
  bit        stall_run = 1'b0;

  // Monitor
  int        cyc = 0;
  bit        prev_clk  [3];
  bit        prev_in   [3];
  bit        prev_done [3];
  int        edges     [3];
  int        last_edge [3];
  int        done_len  [3];
  bit        e_bit;
  done_rec_t d_rec;

  initial begin
    for (int i = 0; i < 3; i++) begin
      prev_clk[i] = 1'b0; prev_in[i] = 1'b0; prev_done[i] = 1'b0;
      edges[i] = 0; last_edge[i] = 0; done_len[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (!rst) begin
          prev_clk[i]  = 1'b0;
          prev_done[i] = 1'b0;
          edges[i]     = 0;
          done_len[i]  = 0;
        end else begin
          if (prog_clk[i] && !prev_clk[i]) begin
            if (exp_bits.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_edge dut%0d: prog_clk rose, none expected", i);
            end else begin
              e_bit = exp_bits.pop_front();
              check($sformatf("prog_in dut%0d bit%0d", i, edges[i]), int'(prog_in[i]), int'(e_bit));
            end
            if (edges[i] > 0 && !stall_run)
              check($sformatf("bit_period dut%0d", i), cyc - last_edge[i], 2 * cdiv(i));
            last_edge[i] = cyc;
            edges[i]++;
          end else if (prog_clk[i] && prev_clk[i]) begin
            check($sformatf("prog_in_stable_hi dut%0d", i), int'(prog_in[i]), int'(prev_in[i]));
          end

          if (done[i]) begin
            done_len[i]++;
            if (!prev_done[i]) begin
              if (exp_done.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done dut%0d: done rose, none expected", i);
              end else begin
                d_rec = exp_done.pop_front();
                check("done_inst", i, d_rec.inst);
                check($sformatf("old_parity dut%0d", i), int'(old_parity[i]), int'(d_rec.parity));
                check($sformatf("edge_count dut%0d", i), edges[i], d_rec.edges);
                check("done_prog_en", int'(prog_en[i]), 0);
                check("done_prog_clk", int'(prog_clk[i]), 0);
              end
              edges[i] = 0;
            end
          end else if (prev_done[i]) begin
            check($sformatf("done_width dut%0d", i), done_len[i], 1);
            done_len[i] = 0;
          end

          prev_clk[i]  = prog_clk[i];
          prev_in[i]   = prog_in[i];
          prev_done[i] = done[i];
        end
      end
    end
  end

  // Stimulus
  logic [7:0]  feed  [8];
  logic [63:0] sw_ch [3] = '{64'd0, 64'd0, 64'd0};

  task automatic run_load(input int i, input int nb, input int stall_idx, input int stall_cyc,
                          input int abort_at, input bit glitch);
    int        len = clen(i);
    int        shifts;
    bit        p = 1'b0;
    int        acc = 0;
    int        idx = 0;
    int        stcnt = 0;
    int        seen = 0;
    bit        pc_prev = 1'b0;
    int        busy_low = 0;
    bit        got_done = 1'b0;
    bit        glitched = 1'b0;
    bit        aborted = 1'b0;
    int        snap = 0;
    done_rec_t rec;

    shifts = (abort_at > 0) ? abort_at : len;
    for (int b = 0; b < len; b++) begin
      bit bv;
      bv = feed[b / 8][b % 8];
      exp_bits.push_back(bv);
      if (b < shifts) begin
        p = p ^ sw_ch[i][len - 1];
        sw_ch[i] = {sw_ch[i][62:0], bv};
      end
    end
    if (abort_at == 0) begin
      rec.inst = i; rec.parity = p; rec.edges = len;
      exp_done.push_back(rec);
    end

    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if (!busy[i]) busy_low++;
      if (done[i]) begin
        got_done = 1'b1;
        break;
      end
      if (prog_clk[i] && !pc_prev) seen++;
      pc_prev = prog_clk[i];
      if (abort_at > 0 && seen == abort_at) begin
        #2 rst = 1'b0;
        #1 check("rst_outputs", int'({byte_ready[i], prog_clk[i], prog_en[i], prog_in[i],
                                     busy[i], done[i], old_parity[i]}), 0);
        snap = hw_edges[i];
        aborted = 1'b1;
        break;
      end

      start[i] = glitch && !glitched && prog_clk[i];
      if (start[i]) glitched = 1'b1;

      byte_valid[i] = 1'b0;
      if (idx < nb) begin
        if (idx == stall_idx && stcnt < stall_cyc) begin
          if (byte_ready[i]) begin
            if (stcnt > 0) begin
              check("stall_prog_clk", int'(prog_clk[i]), 0);
              check("stall_prog_en", int'(prog_en[i]), 1);
            end
            stcnt++;
          end
        end else begin
          byte_valid[i] = 1'b1;
          byte_in[i]    = feed[idx];
        end
      end else begin
        byte_valid[i] = 1'b1;
        byte_in[i]    = 8'hEE;
      end
      if (byte_valid[i] && byte_ready[i]) begin
        acc++;
        if (idx < nb) idx++;
      end
      @(negedge clk);
    end
    byte_valid[i] = 1'b0;
    start[i]      = 1'b0;

    if (aborted) begin
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("no_edges_after_rst", hw_edges[i], snap);
      exp_bits.delete();
    end else begin
      check($sformatf("done_seen dut%0d", i), int'(got_done), 1);
      check($sformatf("bytes_accepted dut%0d", i), acc, nb);
      check($sformatf("busy_during_load dut%0d", i), busy_low, 0);
      @(negedge clk);
      check("busy_after_done", int'(busy[i]), 0);
      check("old_parity_hold", int'(old_parity[i]), int'(p));
      check("bits_left", exp_bits.size(), 0);
    end
  endtask

  initial begin
    start      = '0;
    byte_valid = '0;
    for (int i = 0; i < 3; i++) byte_in[i] = 8'h00;
    for (int k = 0; k < 8; k++) feed[k] = 8'h00;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outputs dut%0d", i),
            int'({byte_ready[i], prog_clk[i], prog_en[i], prog_in[i], busy[i], done[i], old_parity[i]}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 12-bit chain, two bytes back to back
    feed[0] = 8'hA5; feed[1] = 8'h03;
    run_load(0, 2, -1, 0, 0, 1'b0);
    check("chain12_after_load1", int'(hch0), int'(sw_ch[0][11:0]));

    // 10-cycle stall before second byte
    stall_run = 1'b1;
    run_load(0, 2, 1, 10, 0, 1'b0);
    stall_run = 1'b0;

    // reset after the 5th edge, then a full reload
    run_load(0, 2, -1, 0, 5, 1'b0);
    feed[0] = 8'h3C; feed[1] = 8'h0A;
    run_load(0, 2, -1, 0, 0, 1'b0);
    check("chain12_after_reload", int'(hch0), int'(sw_ch[0][11:0]));

    // start pulsed while shifting
    feed[0] = 8'hA5; feed[1] = 8'h03;
    run_load(0, 2, -1, 0, 0, 1'b1);

    // 64-bit chain: all ones, then all zeros
    for (int k = 0; k < 8; k++) feed[k] = 8'hFF;
    run_load(1, 8, -1, 0, 0, 1'b0);
    check("chain64_ones", $countones(hch1), 64);
    for (int k = 0; k < 8; k++) feed[k] = 8'h00;
    run_load(1, 8, -1, 0, 0, 1'b0);
    check("chain64_zero", $countones(hch1), 0);
    check("old_parity_64_ones", int'(old_parity[1]), 0);

    // CLK_DIV=1, 8-bit chain
    feed[0] = 8'h5A;
    run_load(2, 1, -1, 0, 0, 1'b0);
    check("chain8_5a", int'(hch2), int'(sw_ch[2][7:0]));
    feed[0] = 8'h07;
    run_load(2, 1, -1, 0, 0, 1'b0);
    feed[0] = 8'h00;
    run_load(2, 1, -1, 0, 0, 1'b0);
    check("old_parity_odd", int'(old_parity[2]), 1);

    repeat (5) @(negedge clk);
    check("done_queue_empty", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: total configuration bits in the downstream BEL prog chain (1..65535).
REQ-002 SHALL have parameter CLK_DIV, default 2: clk cycles per prog_clk half-period (>=1).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port byte_in, input, 8: bitstream byte.
REQ-007 SHALL have port byte_valid, input, 1: byte_in valid.
REQ-008 SHALL have port byte_ready, output, 1: loader accepts byte_in this cycle.
REQ-009 SHALL have port prog_clk, output, 1: chain shift clock, registered.
REQ-010 SHALL have port prog_en, output, 1: chain shift enable, registered.
REQ-011 SHALL have port prog_in, output, 1: serial config bit into the chain head, registered.
REQ-012 SHALL have port prog_out, input, 1: serial bit from the chain tail.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a load completes.
REQ-015 SHALL have port old_parity, output, 1: XOR of all prog_out bits sampled during the last load.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE.
REQ-017 IDLE: start=1 -> FETCH; bit counter cleared; parity accumulator cleared; prog_en set.
REQ-018 FETCH: byte_ready=1; on byte_valid&byte_ready, latch byte, bit index 0 -> SHIFT_LO; otherwise stay, prog_clk held low, prog_en held high.
REQ-019 SHIFT_LO: prog_in = current byte bit (LSB first), prog_clk=0 for CLK_DIV cycles -> SHIFT_HI.
REQ-020 SHIFT_HI: prog_clk=1 for CLK_DIV cycles; prog_out sampled into parity in the cycle prog_clk rises; prog_in stable throughout.
REQ-021 After SHIFT_HI: if total bits == CHAIN_LEN -> DONE; else if bit index 7 -> FETCH; else next bit -> SHIFT_LO.
REQ-022 Each bit SHALL take exactly 2*CLK_DIV clk cycles when bytes are supplied with no stall.
REQ-023 Bits of the final byte beyond CHAIN_LEN SHALL be discarded; no extra byte is requested.
REQ-024 DONE: prog_clk=0, prog_en=0, done=1 for one cycle -> IDLE; old_parity updated and held until next start.
REQ-025 start SHALL be ignored outside IDLE; byte_valid ignored outside FETCH.
REQ-026 Exactly CHAIN_LEN prog_clk rising edges SHALL occur per load.
REQ-027 prog_in SHALL change only while prog_clk is low.

Reset
REQ-028 rst low SHALL immediately force IDLE; prog_clk=0, prog_en=0, prog_in=0, byte_ready=0, busy=0, done=0, old_parity=0.
REQ-029 Reset mid-load SHALL abort without further prog_clk edges; a subsequent start restarts from bit 0.

Structure
REQ-030 State encodings and the bit-counter width (clog2(CHAIN_LEN+1)) SHALL live in a shared cfg_defs include.
REQ-031 The prog_clk half-period timer SHALL be a sub-module cfg_clk_div (count to CLK_DIV, terminal-count pulse, synchronous clear).

Verification
REQ-032 CHAIN_LEN=12, CLK_DIV=2, bytes 0xA5,0x03 back-to-back -> prog_in at rising edges 1,0,1,0,0,1,0,1,1,1,0,0; 12 edges; done 1 cycle; only 2 bytes accepted.
REQ-033 Load 0xFF x8 into a 64-bit prog chain model, then load 0x00 x8 -> old_parity=0 (64 ones); chain model all zero.
REQ-034 CHAIN_LEN=12, byte_valid delayed 10 cycles before second byte -> prog_clk low and prog_en high throughout stall; bit sequence unchanged.
REQ-035 rst low after 5th rising edge -> all outputs reset value immediately; no further edges; new start produces 12 full edges.
REQ-036 start pulsed during SHIFT_HI -> ignored; edge count stays 12; busy high from start to DONE.
REQ-037 CLK_DIV=1, CHAIN_LEN=8, byte 0x5A -> prog_clk period 2 clk cycles; done asserted 1 cycle after final SHIFT_HI; total 8 edges.
